// File: rtl/data_path_pkg.sv
// Shared types for the memory access controller: FSM states, access size
// codes, fault codes and the alignment rule.
package data_path_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    GAP  = 3'd2,
    ACC1 = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } dl_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ALIGN   = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

  // An access is misaligned when its address is not a multiple of its size.
  function automatic logic is_misaligned(input dl_e size, input logic [2:0] a);
    case (size)
      HALF:    return a[0];
      WORD:    return |a[1:0];
      DWORD:   return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering between the control unit and the memory bus:
// write replication plus byte enables, and read extraction with extension.
module lane_align
  import data_path_pkg::*;
#(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int LB = $clog2(NB)
) (
  input  dl_e            size,
  input  logic           sext,
  input  logic [LB-1:0]  lane,
  input  logic [DW-1:0]  wdata_in,
  input  logic [DW-1:0]  rdata_in,
  output logic [DW-1:0]  wdata_out,
  output logic [NB-1:0]  be_out,
  output logic [DW-1:0]  rdata_out
);

  localparam int DB = LB + 3;

  logic [DB-1:0] byte_base;
  logic [DB-1:0] half_base;
  logic [DB-1:0] word_base;
  logic [7:0]    sel_b;
  logic [15:0]   sel_h;
  logic [31:0]   sel_w;

  // Bit offsets of the addressed byte, halfword and 32-bit slot.
  assign byte_base = {lane, 3'b000};
  assign half_base = byte_base & ~DB'(15);
  assign word_base = byte_base & ~DB'(31);
  assign sel_b     = rdata_in[byte_base +: 8];
  assign sel_h     = rdata_in[half_base +: 16];
  assign sel_w     = rdata_in[word_base +: 32];

  // Size-dependent lane placement and extraction.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    wdata_out = '0;
    be_out    = '0;
    rdata_out = '0;
    case (size)
      BYTE: begin
        wdata_out = {NB{wdata_in[7:0]}};
        be_out    = NB'(1) << lane;
        rdata_out = {{(DW-8){sext & sel_b[7]}}, sel_b};
      end
      HALF: begin
        wdata_out = {(NB/2){wdata_in[15:0]}};
        be_out    = NB'(3) << (lane & ~LB'(1));
        rdata_out = {{(DW-16){sext & sel_h[15]}}, sel_h};
      end
      WORD: begin
        wdata_out = {(DW/32){wdata_in[31:0]}};
        be_out    = NB'(15) << (lane & ~LB'(3));
        rdata_out = DW'(sel_w);
      end
      default: begin
        wdata_out = {(DW/32){wdata_in[31:0]}};
        be_out    = NB'(15) << (lane & ~LB'(3));
        rdata_out = rdata_in;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: takes one sized request from the control unit,
// runs the MOV/MOC handshake for one or two beats, and reports alignment
// and timeout faults instead of stalling forever.
module mem_access_ctrl
  import data_path_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        dl,
  input  logic              sext,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  input  logic [DW-1:0]     wdata_hi,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fault,
  output logic [DW-1:0]     rdata,
  output logic [DW-1:0]     rdata_hi,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_be,
  input  logic              mem_moc,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state;
  logic            rw_q;
  dl_e             dl_q;
  logic            sext_q;
  logic [LB-1:0]   lane_q;
  logic [DW-1:0]   wdata_hi_q;
  logic [CW-1:0]   wait_cnt;

  logic            in_idle;
  dl_e             la_size;
  logic [LB-1:0]   la_lane;
  logic [DW-1:0]   la_wdata;
  logic [NB-1:0]   la_be;
  logic [DW-1:0]   la_wdata_out;
  logic [DW-1:0]   la_rdata;

  // In IDLE the aligner places the incoming request's beat-0 data; afterwards
  // it works from the latched request (beat-1 data and read extraction).
  assign in_idle  = (state == IDLE);
  assign la_size  = in_idle ? dl_e'(dl) : dl_q;
  assign la_lane  = in_idle ? addr[LB-1:0] : lane_q;
  assign la_wdata = in_idle ? wdata : wdata_hi_q;

  lane_align #(.DW(DW)) u_lane_align (
    .size      (la_size),
    .sext      (sext_q),
    .lane      (la_lane),
    .wdata_in  (la_wdata),
    .rdata_in  (mem_rdata),
    .wdata_out (la_wdata_out),
    .be_out    (la_be),
    .rdata_out (la_rdata)
  );

  // Access FSM with registered handshake, status and data outputs.
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= FAULT_NONE;
      rdata      <= '0;
      rdata_hi   <= '0;
      mem_mov    <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      rw_q       <= 1'b0;
      dl_q       <= BYTE;
      sext_q     <= 1'b0;
      lane_q     <= '0;
      wdata_hi_q <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            rw_q       <= rw;
            dl_q       <= dl_e'(dl);
            sext_q     <= sext;
            lane_q     <= addr[LB-1:0];
            wdata_hi_q <= wdata_hi;
            mem_rw     <= rw;
            fault      <= FAULT_NONE;
            busy       <= 1'b1;
            if (is_misaligned(dl_e'(dl), addr[2:0])) begin
              fault <= FAULT_ALIGN;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              wait_cnt  <= '0;
              mem_mov   <= 1'b1;
              mem_addr  <= addr & ~AW'(NB - 1);
              mem_wdata <= la_wdata_out;
              mem_be    <= la_be;
              state     <= ACC0;
            end
          end
        end
        ACC0, ACC1: begin
          if (mem_moc) begin
            wait_cnt <= '0;
            mem_mov  <= 1'b0;
            if (state == ACC0) begin
              if (rw_q) rdata <= la_rdata;
              if (dl_q == DWORD) begin
                state <= GAP;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              if (rw_q) rdata_hi <= mem_rdata;
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            mem_mov <= 1'b0;
            fault   <= FAULT_TIMEOUT;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        GAP: begin
          wait_cnt  <= '0;
          mem_mov   <= 1'b1;
          mem_addr  <= mem_addr + AW'(NB);
          mem_wdata <= la_wdata_out;
          mem_be    <= la_be;
          state     <= ACC1;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (DW=32): a transaction-level model
// expands each request into its expected cycle trace, the bench plays the
// memory from that trace, and a negedge process compares every cycle.
module tb_mem_access_ctrl;

  localparam int DW      = 32;
  localparam int AW      = 9;
  localparam int TIMEOUT = 15;

  logic          main_clk = 1'b0;
  logic          reset;
  logic          req, rw, sext;
  logic [1:0]    dl;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, wdata_hi;
  logic          busy, done;
  logic [1:0]    fault;
  logic [DW-1:0] rdata, rdata_hi;
  logic          mem_mov, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_moc;
  logic [DW-1:0] mem_rdata;

  mem_access_ctrl #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .main_clk  (main_clk),
    .reset     (reset),
    .req       (req),
    .rw        (rw),
    .dl        (dl),
    .sext      (sext),
    .addr      (addr),
    .wdata     (wdata),
    .wdata_hi  (wdata_hi),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .rdata_hi  (rdata_hi),
    .mem_mov   (mem_mov),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_moc   (mem_moc),
    .mem_rdata (mem_rdata)
  );

  always #5 main_clk = ~main_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One expected cycle: what the bench drives as memory plus what the DUT must show.
  typedef struct packed {
    logic          moc;
    logic [31:0]   rd;
    logic          busy;
    logic          done;
    logic          mov;
    logic          rw;
    logic [1:0]    fault;
    logic [8:0]    addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic [31:0]   rdata;
    logic [31:0]   rdata_hi;
  } cyc_t;

  // Architectural state remembered across accesses.
  logic [31:0] m_rdata, m_rdata_hi;
  logic [1:0]  m_fault;

  cyc_t exp_c;
  logic exp_valid = 1'b0;
  int   cur_k;

  // Observations gathered per access for the literal checks.
  int         mov_cnt, done_cnt, done_k;
  logic       seen_any;
  logic [8:0] first_addr, last_addr;
  logic [31:0] seen_wdata;
  logic [3:0] seen_be;

  function automatic cyc_t idle_cycle();
    cyc_t c;
    c.moc      = 1'b0;
    c.rd       = $urandom;
    c.busy     = 1'b0;
    c.done     = 1'b0;
    c.mov      = 1'b0;
    c.rw       = 1'b0;
    c.fault    = m_fault;
    c.addr     = '0;
    c.wdata    = '0;
    c.be       = '0;
    c.rdata    = m_rdata;
    c.rdata_hi = m_rdata_hi;
    return c;
  endfunction

  function automatic logic [31:0] place_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] place_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'(1 << lane);
      2'b01:   return 4'(3 << lane);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic s,
                                          input logic [1:0] lane, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * lane);
    case (size)
      2'b00: begin
        v = v & 32'h0000_00FF;
        if (s && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = v & 32'h0000_FFFF;
        if (s && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // Expand one request into its cycle trace, then play it. w0/w1 are the wait
  // cycles before MOC on each beat (>= TIMEOUT means MOC never comes).
  // abort_at >= 0 asserts reset in that trace cycle and ends the access there.
  task automatic run_access(input logic rw_i, input logic [1:0] dl_i, input logic s_i,
                            input logic [8:0] a_i, input logic [31:0] wd, input logic [31:0] wdh,
                            input int w0, input int w1, input logic [31:0] rd0,
                            input logic [31:0] rd1, input int abort_at);
    cyc_t q[$];
    cyc_t c;
    int   nbeats;
    int   w, n;
    nbeats = (dl_i == 2'b11) ? 2 : 1;
    q.push_back(idle_cycle());
    if ((int'(a_i) % (1 << dl_i)) != 0) begin
      m_fault = 2'b01;
      c = idle_cycle();
      c.busy = 1'b1;
      c.done = 1'b1;
      q.push_back(c);
    end else begin
      m_fault = 2'b00;
      for (int b = 0; b < nbeats; b++) begin
        w = (b == 0) ? w0 : w1;
        n = (w >= TIMEOUT) ? TIMEOUT : w + 1;
        if (b == 1) begin
          c = idle_cycle();
          c.busy = 1'b1;
          q.push_back(c);
        end
        for (int i = 0; i < n; i++) begin
          c = idle_cycle();
          c.busy  = 1'b1;
          c.mov   = 1'b1;
          c.rw    = rw_i;
          c.addr  = 9'((int'(a_i) / 4) * 4 + 4 * b);
          c.wdata = place_wdata(dl_i, (b == 0) ? wd : wdh);
          c.be    = place_be(dl_i, a_i[1:0]);
          c.moc   = (i == w);
          if (i == w) c.rd = (b == 0) ? rd0 : rd1;
          q.push_back(c);
        end
        if (w >= TIMEOUT) begin
          m_fault = 2'b10;
          break;
        end
        if (rw_i) begin
          if (b == 0) m_rdata = extract(dl_i, s_i, a_i[1:0], rd0);
          else        m_rdata_hi = rd1;
        end
      end
      c = idle_cycle();
      c.busy = 1'b1;
      c.done = 1'b1;
      q.push_back(c);
    end
    q.push_back(idle_cycle());

    mov_cnt  = 0;
    done_cnt = 0;
    done_k   = -1;
    seen_any = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      @(posedge main_clk);
      #1;
      cur_k     = k;
      exp_c     = q[k];
      exp_valid = 1'b1;
      mem_moc   = q[k].moc;
      mem_rdata = q[k].rd;
      if (k == 0) begin
        req = 1'b1; rw = rw_i; dl = dl_i; sext = s_i; addr = a_i; wdata = wd; wdata_hi = wdh;
      end else begin
        req      = (k == q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
        rw       = 1'($urandom_range(0, 1));
        dl       = 2'($urandom_range(0, 3));
        sext     = 1'($urandom_range(0, 1));
        addr     = 9'($urandom_range(0, 511));
        wdata    = $urandom;
        wdata_hi = $urandom;
      end
      if (k == abort_at) begin
        @(negedge main_clk);
        #2;
        exp_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rst_mid_mem_mov", mem_mov, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_fault", fault, 2'b00);
        check("rst_mid_rdata", rdata, 32'h0);
        check("rst_mid_rdata_hi", rdata_hi, 32'h0);
        m_rdata    = '0;
        m_rdata_hi = '0;
        m_fault    = '0;
        req        = 1'b0;
        mem_moc    = 1'b0;
        @(posedge main_clk);
        #1;
        reset = 1'b0;
        return;
      end
    end
    @(negedge main_clk);
    #1;
    exp_valid = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the expanded trace.
  always @(negedge main_clk) begin
    if (exp_valid) begin
      check("busy", busy, exp_c.busy);
      check("done", done, exp_c.done);
      check("mem_mov", mem_mov, exp_c.mov);
      check("fault", fault, exp_c.fault);
      check("rdata", rdata, exp_c.rdata);
      check("rdata_hi", rdata_hi, exp_c.rdata_hi);
      if (exp_c.mov) begin
        check("mem_addr", mem_addr, exp_c.addr);
        check("mem_be", mem_be, exp_c.be);
        check("mem_rw", mem_rw, exp_c.rw);
        if (!exp_c.rw) check("mem_wdata", mem_wdata, exp_c.wdata);
      end
      if (mem_mov) begin
        mov_cnt++;
        if (!seen_any) first_addr = mem_addr;
        seen_any   = 1'b1;
        last_addr  = mem_addr;
        seen_wdata = mem_wdata;
        seen_be    = mem_be;
      end
      if (done) begin
        done_cnt++;
        done_k = cur_k;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] d;
    logic [8:0] a;
    int         wa, wb, sel;
    reset = 1'b1;
    req = 1'b0; rw = 1'b0; dl = 2'b00; sext = 1'b0; addr = '0;
    wdata = '0; wdata_hi = '0; mem_moc = 1'b0; mem_rdata = '0;
    m_rdata = '0; m_rdata_hi = '0; m_fault = '0;
    repeat (3) @(posedge main_clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_mem_mov", mem_mov, 1'b0);
    check("reset_fault", fault, 2'b00);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rdata_hi", rdata_hi, 32'h0);
    check("reset_mem_addr", mem_addr, 9'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_mem_be", mem_be, 4'h0);
    reset = 1'b0;

    // Zero-wait word read.
    run_access(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0, -1);
    check("word_rd_rdata", rdata, 32'hDEADBEEF);
    check("word_rd_mov_cycles", mov_cnt, 1);
    check("word_rd_done_cycle", done_k, 2);
    check("word_rd_fault", fault, 2'b00);

    // Byte read at lane 3, signed then unsigned.
    run_access(1'b1, 2'b00, 1'b1, 9'h013, 32'h0, 32'h0, 0, 0, 32'h80FF1234, 32'h0, -1);
    check("byte_sext_rdata", rdata, 32'hFFFFFF80);
    run_access(1'b1, 2'b00, 1'b0, 9'h013, 32'h0, 32'h0, 0, 0, 32'h80FF1234, 32'h0, -1);
    check("byte_zext_rdata", rdata, 32'h00000080);

    // Halfword write to the upper half.
    run_access(1'b0, 2'b01, 1'b0, 9'h022, 32'h0000ABCD, 32'h0, 1, 0, 32'h0, 32'h0, -1);
    check("half_wr_wdata", seen_wdata, 32'hABCDABCD);
    check("half_wr_be", seen_be, 4'b1100);
    check("half_wr_addr", first_addr, 9'h020);
    check("half_wr_rdata_kept", rdata, 32'h00000080);

    // Doubleword read, two wait cycles on each beat.
    run_access(1'b1, 2'b11, 1'b0, 9'h008, 32'h0, 32'h0, 2, 2, 32'h11112222, 32'h33334444, -1);
    check("dword_addr0", first_addr, 9'h008);
    check("dword_addr1", last_addr, 9'h00C);
    check("dword_mov_cycles", mov_cnt, 6);
    check("dword_done_pulses", done_cnt, 1);
    check("dword_done_cycle", done_k, 8);
    check("dword_rdata", rdata, 32'h11112222);
    check("dword_rdata_hi", rdata_hi, 32'h33334444);

    // Misaligned word.
    run_access(1'b1, 2'b10, 1'b0, 9'h006, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, -1);
    check("misalign_done_cycle", done_k, 1);
    check("misalign_fault", fault, 2'b01);
    check("misalign_mov_cycles", mov_cnt, 0);
    check("misalign_rdata_kept", rdata, 32'h11112222);

    // MOC never arrives.
    run_access(1'b1, 2'b10, 1'b0, 9'h040, 32'h0, 32'h0, TIMEOUT + 5, 0, 32'h5555AAAA, 32'h0, -1);
    check("timeout_mov_cycles", mov_cnt, 15);
    check("timeout_fault", fault, 2'b10);
    check("timeout_done_pulses", done_cnt, 1);
    check("timeout_rdata_kept", rdata, 32'h11112222);

    // MOC on the last permitted cycle still completes.
    run_access(1'b1, 2'b10, 1'b0, 9'h044, 32'h0, 32'h0, TIMEOUT - 1, 0, 32'h0BADF00D, 32'h0, -1);
    check("late_moc_mov_cycles", mov_cnt, 15);
    check("late_moc_fault", fault, 2'b00);
    check("late_moc_rdata", rdata, 32'h0BADF00D);

    // Timeout on the second beat keeps beat-0 data.
    run_access(1'b1, 2'b11, 1'b0, 9'h010, 32'h0, 32'h0, 0, TIMEOUT + 2, 32'hCAFE0001, 32'h0, -1);
    check("acc1_timeout_fault", fault, 2'b10);
    check("acc1_timeout_rdata", rdata, 32'hCAFE0001);
    check("acc1_timeout_rdata_hi", rdata_hi, 32'h33334444);

    // Reset in the middle of beat 1, then a normal access.
    run_access(1'b1, 2'b11, 1'b0, 9'h018, 32'h0, 32'h0, 1, 3, 32'h1, 32'h2, 5);
    run_access(1'b1, 2'b10, 1'b0, 9'h100, 32'h0, 32'h0, 0, 0, 32'h12345678, 32'h0, -1);
    check("after_reset_rdata", rdata, 32'h12345678);
    check("after_reset_done_cycle", done_k, 2);

    // Randomised accesses against the model.
    for (int t = 0; t < 150; t++) begin
      d = 2'($urandom_range(0, 3));
      a = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 9) < 8) a = a & ~9'((1 << d) - 1);
      sel = $urandom_range(0, 19);
      wa  = (sel == 0) ? TIMEOUT : (sel == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
      sel = $urandom_range(0, 19);
      wb  = (sel == 0) ? TIMEOUT + 3 : $urandom_range(0, 3);
      run_access(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), a,
                 $urandom, $urandom, wa, wb, $urandom, $urandom, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
